// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the MEM stage: accepts one datapath op, checks
// alignment, issues a single word-aligned memory access with byte enables,
// extracts/extends load data and returns a one-cycle result pulse. A cycle
// timeout aborts the access if the memory never acknowledges.
module lsu_mem_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        res_valid,
  output logic [31:0] res_rdata,
  output logic [1:0]  res_exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [2:0]  type_q, type_n;
  logic [1:0]  lo_q, lo_n;
  logic [7:0]  cnt_q, cnt_n;

  logic        op_ready_n, res_valid_n, mem_req_n, mem_we_n;
  logic [31:0] res_rdata_n, mem_addr_n, mem_wdata_n;
  logic [1:0]  res_exc_n;
  logic [3:0]  mem_be_n;

  logic        in_store, in_word, in_half, in_misaligned;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  logic [15:0] sel_half;
  logic [7:0]  sel_byte;
  logic [31:0] load_data;

  // Decode the incoming op: size class, alignment, byte enables, lane data
  always_comb begin
    in_store      = (op_type == 3'b101) || (op_type == 3'b110) || (op_type == 3'b111);
    in_word       = (op_type == 3'b000) || (op_type == 3'b101);
    in_half       = (op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b110);
    in_misaligned = (in_word && (op_addr[1:0] != 2'b00)) || (in_half && op_addr[0]);
    if (in_word) begin
      in_be = 4'b1111;
    end else if (in_half) begin
      in_be = op_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      in_be = 4'b0001 << op_addr[1:0];
    end
    case (op_type)
      3'b101:  in_wdata = op_wdata;
      3'b110:  in_wdata = {2{op_wdata[15:0]}};
      3'b111:  in_wdata = {4{op_wdata[7:0]}};
      default: in_wdata = 32'h0;
    endcase
  end

  // Pick the addressed lane of the read word and extend it per load type
  always_comb begin
    sel_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lo_q)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    case (type_q)
      3'b000:  load_data = mem_rdata;
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = {16'h0, sel_half};
      3'b011:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'h0, sel_byte};
      default: load_data = 32'h0;
    endcase
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n     = state;
    type_n      = type_q;
    lo_n        = lo_q;
    cnt_n       = cnt_q;
    op_ready_n  = op_ready;
    res_valid_n = res_valid;
    res_rdata_n = res_rdata;
    res_exc_n   = res_exc;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_be_n    = mem_be;
    mem_wdata_n = mem_wdata;
    case (state)
      IDLE: begin
        if (op_valid) begin
          type_n     = op_type;
          lo_n       = op_addr[1:0];
          cnt_n      = 8'd0;
          op_ready_n = 1'b0;
          if (in_misaligned) begin
            state_n     = RESP;
            res_valid_n = 1'b1;
            res_rdata_n = 32'h0;
            res_exc_n   = in_store ? 2'b10 : 2'b01;
          end else begin
            state_n     = REQ;
            mem_req_n   = 1'b1;
            mem_we_n    = in_store;
            mem_addr_n  = {op_addr[31:2], 2'b00};
            mem_be_n    = in_be;
            mem_wdata_n = in_wdata;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_n     = RESP;
          mem_req_n   = 1'b0;
          res_valid_n = 1'b1;
          res_rdata_n = load_data;
          res_exc_n   = 2'b00;
        end else if (cnt_q == LAST_WAIT) begin
          state_n     = RESP;
          mem_req_n   = 1'b0;
          res_valid_n = 1'b1;
          res_rdata_n = 32'h0;
          res_exc_n   = 2'b11;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_n     = IDLE;
        op_ready_n  = 1'b1;
        res_valid_n = 1'b0;
        res_rdata_n = 32'h0;
        res_exc_n   = 2'b00;
        cnt_n       = 8'd0;
        mem_req_n   = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = 32'h0;
        mem_be_n    = 4'h0;
        mem_wdata_n = 32'h0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      type_q    <= 3'b000;
      lo_q      <= 2'b00;
      cnt_q     <= 8'd0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_rdata <= 32'h0;
      res_exc   <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      state     <= state_n;
      type_q    <= type_n;
      lo_q      <= lo_n;
      cnt_q     <= cnt_n;
      op_ready  <= op_ready_n;
      res_valid <= res_valid_n;
      res_rdata <= res_rdata_n;
      res_exc   <= res_exc_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_be    <= mem_be_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: a reference model predicts each
// memory request and result from load/store rules; a responder acks after a
// chosen delay; a monitor pops and compares whenever the DUT presents output.
module tb_lsu_mem_initiator;

  localparam int TIMEOUT = 4;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_type = 3'd0;
  logic [31:0] op_addr = 32'h0;
  logic [31:0] op_wdata = 32'h0;
  logic        res_valid;
  logic [31:0] res_rdata;
  logic [1:0]  res_exc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu_mem_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata),
    .res_valid(res_valid), .res_rdata(res_rdata), .res_exc(res_exc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] rdata; logic [1:0] exc; int reqCycles; int latency; } res_t;
  typedef struct { int ackAt; logic [31:0] data; } cfg_t;

  req_t reqQ[$];
  res_t resQ[$];
  cfg_t cfgQ[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int lastAccept = 0;
  int acceptNeg = 0;
  int lastResNeg = 0;
  logic lateAck = 1'b0;

  // Edge counter used to measure latencies
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: expected request and result from the op rules
  function automatic void model(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                                input int ackAt, input logic [31:0] rd,
                                output bit access, output req_t rq, output res_t rs);
    int size, off;
    bit st, sgn;
    longint unsigned mask, val, mult;
    size = (t == LW || t == SW) ? 4 : (t == LH || t == LHU || t == SH) ? 2 : 1;
    st   = (t >= SW);
    sgn  = (t == LH || t == LB);
    off  = int'(a % 32'd4);
    mask = (64'd1 << (8 * size)) - 64'd1;
    mult = (size == 4) ? 64'd1 : (size == 2) ? 64'h10001 : 64'h1010101;
    rq.addr = 32'h0; rq.we = 1'b0; rq.be = 4'h0; rq.wdata = 32'h0;
    rs.rdata = 32'h0; rs.exc = 2'd0;
    if (off % size != 0) begin
      access = 0;
      rs.exc = st ? 2'd2 : 2'd1;
      rs.reqCycles = 0;
      rs.latency = 1;
    end else begin
      access = 1;
      rq.addr  = a - 32'(off);
      rq.we    = st;
      rq.be    = 4'(((1 << size) - 1) << off);
      rq.wdata = st ? 32'((64'(w) & mask) * mult) : 32'h0;
      if (ackAt >= 1 && ackAt <= TIMEOUT) begin
        rs.exc = 2'd0;
        rs.reqCycles = ackAt;
        rs.latency = ackAt + 1;
        if (!st) begin
          val = ({32'h0, rd} >> (8 * off)) & mask;
          if (sgn && val >= (mask + 64'd1) / 64'd2) val = val + (64'hFFFFFFFF - mask);
          rs.rdata = val[31:0];
        end
      end else begin
        rs.exc = 2'd3;
        rs.reqCycles = TIMEOUT;
        rs.latency = TIMEOUT + 1;
      end
    end
  endfunction

  // Present one op, queue its expectations, return once it has been accepted
  task automatic applyStimulus(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                               input int ackAt, input logic [31:0] rd, input bit hold);
    bit access, accepted;
    req_t rq;
    res_t rs;
    cfg_t cf;
    model(t, a, w, ackAt, rd, access, rq, rs);
    if (access) begin
      reqQ.push_back(rq);
      cf.ackAt = ackAt;
      cf.data = rd;
      cfgQ.push_back(cf);
    end
    resQ.push_back(rs);
    op_valid = 1'b1;
    op_type = t;
    op_addr = a;
    op_wdata = w;
    accepted = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (op_ready) begin
        accepted = 1;
        acceptNeg = cyc;
        break;
      end
    end
    checkOutput("op_accepted", 64'(accepted), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) op_valid = 1'b0;
  endtask

  // Wait (bounded) until every queued result has been seen
  task automatic waitDrain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resQ.size() == 0) break;
    end
    checkOutput("drain", 64'(resQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Responder: ack the k-th request cycle, random ack noise while idle
  int   rspCnt = 0;
  bit   rspActive = 0;
  cfg_t rspCur;
  always @(negedge clk) begin
    if (mem_req) begin
      if (!rspActive) begin
        rspActive = 1;
        rspCnt = 0;
        if (cfgQ.size() != 0) rspCur = cfgQ.pop_front();
        else begin
          rspCur.ackAt = 1;
          rspCur.data = 32'h0;
        end
      end
      rspCnt++;
      mem_ack = (rspCnt == rspCur.ackAt);
      mem_rdata = mem_ack ? rspCur.data : $urandom();
    end else begin
      rspActive = 0;
      mem_ack = lateAck | ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
    end
  end

  // Monitor: compare requests and results against the scoreboard queues
  bit   prevReq = 0, prevRes = 0, postRes = 0;
  int   reqRun = 0;
  req_t curReq;
  res_t curRes;
  always @(negedge clk) begin
    if (reset) begin
      prevReq = 0;
      prevRes = 0;
      postRes = 0;
      reqRun = 0;
    end else begin
      if (postRes) begin
        checkOutput("idle_op_ready", 64'(op_ready), 64'd1);
        checkOutput("idle_mem_clear", 64'({mem_req, mem_we, mem_be, mem_addr}), 64'd0);
        checkOutput("idle_wdata_clear", 64'(mem_wdata), 64'd0);
        postRes = 0;
      end
      if (mem_req) begin
        reqRun++;
        checkOutput("busy_op_ready", 64'(op_ready), 64'd0);
        if (!prevReq) begin
          checkOutput("req_expected", 64'(reqQ.size() != 0), 64'd1);
          if (reqQ.size() != 0) begin
            curReq = reqQ.pop_front();
            checkOutput("mem_addr", 64'(mem_addr), 64'(curReq.addr));
            checkOutput("mem_we", 64'(mem_we), 64'(curReq.we));
            checkOutput("mem_be", 64'(mem_be), 64'(curReq.be));
            checkOutput("mem_wdata", 64'(mem_wdata), 64'(curReq.wdata));
          end
        end else begin
          checkOutput("req_stable", 64'({mem_we, mem_be, mem_addr}),
                      64'({curReq.we, curReq.be, curReq.addr}));
          checkOutput("req_stable_wdata", 64'(mem_wdata), 64'(curReq.wdata));
        end
      end
      if (res_valid) begin
        checkOutput("res_single_pulse", 64'(prevRes), 64'd0);
        checkOutput("res_op_ready", 64'(op_ready), 64'd0);
        checkOutput("res_expected", 64'(resQ.size() != 0), 64'd1);
        if (resQ.size() != 0) begin
          curRes = resQ.pop_front();
          checkOutput("res_rdata", 64'(res_rdata), 64'(curRes.rdata));
          checkOutput("res_exc", 64'(res_exc), 64'(curRes.exc));
          checkOutput("req_cycles", 64'(reqRun), 64'(curRes.reqCycles));
          checkOutput("latency", 64'(cyc - lastAccept), 64'(curRes.latency));
        end
        reqRun = 0;
        lastResNeg = cyc;
        postRes = 1;
      end
      if (op_valid && op_ready) lastAccept = cyc;
      prevReq = mem_req;
      prevRes = res_valid;
    end
  end

  // Directed cases, reset abort, back-to-back, then randomized traffic
  initial begin
    int pulses;
    logic [31:0] ra, rw, rd;
    logic [2:0]  rt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_op_ready", 64'(op_ready), 64'd1);
    checkOutput("rst_res", 64'({res_valid, res_exc, res_rdata}), 64'd0);
    checkOutput("rst_mem", 64'({mem_req, mem_we, mem_be, mem_addr}), 64'd0);
    checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(LW,  32'h10, 32'h0,    1, 32'h8899AABB, 0); waitDrain();
    applyStimulus(LB,  32'h13, 32'h0,    2, 32'h80112233, 0); waitDrain();
    applyStimulus(LBU, 32'h13, 32'h0,    1, 32'h80112233, 0); waitDrain();
    applyStimulus(LH,  32'h22, 32'h0,    3, 32'h9ABC0001, 0); waitDrain();
    applyStimulus(LHU, 32'h22, 32'h0,    1, 32'h9ABC0001, 0); waitDrain();
    applyStimulus(SH,  32'h06, 32'h1234, 2, 32'h0,        0); waitDrain();
    applyStimulus(SB,  32'h01, 32'hA5,   1, 32'h0,        0); waitDrain();
    applyStimulus(SW,  32'h02, 32'h5555, 1, 32'h0,        0); waitDrain();
    applyStimulus(LH,  32'h01, 32'h0,    1, 32'h0,        0); waitDrain();
    applyStimulus(LW,  32'h30, 32'h0,    0, 32'h0,        0); waitDrain();
    applyStimulus(LW,  32'h30, 32'h0,    TIMEOUT, 32'hCAFEF00D, 0); waitDrain();

    applyStimulus(LW, 32'h40, 32'h0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    reqQ.delete();
    resQ.delete();
    cfgQ.delete();
    lateAck = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_req", 64'(mem_req), 64'd0);
    checkOutput("abort_op_ready", 64'(op_ready), 64'd1);
    checkOutput("abort_res_valid", 64'(res_valid), 64'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    checkOutput("late_ack_ignored", 64'(pulses), 64'd0);
    lateAck = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(LW, 32'h50, 32'h0,        2, 32'h01234567, 1);
    applyStimulus(SW, 32'h54, 32'hDEADBEEF, 1, 32'h0,        0);
    checkOutput("b2b_accept_gap", 64'(acceptNeg - lastResNeg), 64'd1);
    waitDrain();

    for (int n = 0; n < 150; n++) begin
      rt = 3'($urandom_range(0, 7));
      ra = $urandom();
      rw = $urandom();
      rd = $urandom();
      applyStimulus(rt, ra, rw, $urandom_range(0, TIMEOUT + 1), rd, 1);
    end
    op_valid = 1'b0;
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global guard against a hung simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
